divisor_restas: RTL and testbench

Sequential 4-bit unsigned divider built around a single ripple-borrow subtractor. The subtractor is shared across cycles: the controller repeatedly subtracts the divisor from a running remainder and counts the successful subtractions. It is the first clocked consumer of the subtractor datapath. A start/done handshake lets a higher-level FSM or test harness launch one division at a time.

---
 rtl/divisor_restas_pkg.sv | 14 +
 rtl/resta4.sv | 30 +++
 rtl/divisor_restas.sv | 111 +++++++++++
 tb/tb_divisor_restas.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/divisor_restas_pkg.sv
// Shared definitions for the divisor_restas sequential divider.
// Holds the controller state encoding and the default operand width.
package divisor_restas_pkg;

  localparam int unsigned W_DEF = 4;

  // Controller states; encoding 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RESTA = 2'b01,
    FIN   = 2'b10
  } state_e;

endpackage

// File: rtl/resta4.sv
// Purely combinational W-bit ripple-borrow subtractor.
// Ports:
//   a, b   : unsigned operands
//   r      : a - b modulo 2^W
//   borrow : 1 when a < b (borrow out of the top stage)
module resta4
  import divisor_restas_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] r,
  output logic         borrow
);

  logic [W:0] bc;

  // Full-subtractor chain, LSB first.
  always_comb begin
    r     = '0;
    bc    = '0;
    for (int i = 0; i < int'(W); i++) begin
      r[i]    = a[i] ^ b[i] ^ bc[i];
      bc[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bc[i]);
    end
    borrow = bc[W];
  end

endmodule

// File: rtl/divisor_restas.sv
// Sequential unsigned divider by repeated subtraction through one shared
// ripple-borrow subtractor, with a start/ready/done handshake.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   start               : launch a division, honoured only while ready
//   dividend, divisor   : operands, sampled with start
//   ready               : idle, start will be accepted
//   done                : one-cycle pulse, results valid
//   quotient, remainder : results, held until the next done
//   div_zero            : divisor was zero for the last completed division
module divisor_restas
  import divisor_restas_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_zero
);

  state_e       state_q, state_n;
  logic [W-1:0] rem_q, rem_n;
  logic [W-1:0] div_q, div_n;
  logic [W-1:0] cnt_q, cnt_n;
  logic [W-1:0] quo_n, remo_n;
  logic         dz_n;
  logic [W-1:0] diff;
  logic         borrow;

  resta4 #(.W(W)) u_resta (
    .a      (rem_q),
    .b      (div_q),
    .r      (diff),
    .borrow (borrow)
  );

  // Next-state and next-register values.
  always_comb begin
    state_n = state_q;
    rem_n   = rem_q;
    div_n   = div_q;
    cnt_n   = cnt_q;
    quo_n   = quotient;
    remo_n  = remainder;
    dz_n    = div_zero;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_n = dividend;
          div_n = divisor;
          cnt_n = '0;
          if (divisor == '0) begin
            state_n = FIN;
            quo_n   = '1;
            remo_n  = dividend;
            dz_n    = 1'b1;
          end else begin
            state_n = RESTA;
          end
        end
      end
      RESTA: begin
        if (!borrow) begin
          rem_n = diff;
          cnt_n = cnt_q + W'(1);
        end else begin
          quo_n   = cnt_q;
          remo_n  = rem_q;
          dz_n    = 1'b0;
          state_n = FIN;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and output registers; ready/done track the next state
  // so they are registered copies of the state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
    end else begin
      state_q   <= state_n;
      rem_q     <= rem_n;
      div_q     <= div_n;
      cnt_q     <= cnt_n;
      quotient  <= quo_n;
      remainder <= remo_n;
      div_zero  <= dz_n;
      ready     <= (state_n == IDLE);
      done      <= (state_n == FIN);
    end
  end

endmodule

// File: tb/tb_divisor_restas.sv
// Self-checking bench for divisor_restas: a latency/result model built from
// plain integer division, compared every cycle, plus directed literal checks.
module tb_divisor_restas;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       ready;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_zero;

  int vectors;
  int errors;

  divisor_restas #(.W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 busy, 2 done cycle. A request with true quotient q
  // needs q+1 edges after the accepting edge; divide-by-zero needs none.
  int         m_mode;
  int         m_left;
  logic [3:0] m_q, m_r, p_q, p_r;
  logic       m_dz, p_dz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_left = 0;
      m_q = 4'd0; m_r = 4'd0; m_dz = 1'b0;
      p_q = 4'd0; p_r = 4'd0; p_dz = 1'b0;
    end else begin
      case (m_mode)
        0: if (start) begin
          if (divisor == 4'd0) begin
            p_q = 4'd15; p_r = dividend; p_dz = 1'b1; m_left = 0;
          end else begin
            p_q = 4'(int'(dividend) / int'(divisor));
            p_r = 4'(int'(dividend) % int'(divisor));
            p_dz = 1'b0;
            m_left = int'(p_q) + 1;
          end
          m_mode = 1;
        end
        1: m_left = m_left - 1;
        default: m_mode = 0;
      endcase
      if (m_mode == 1 && m_left == 0) begin
        m_mode = 2; m_q = p_q; m_r = p_r; m_dz = p_dz;
      end
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("ready", 4'(ready), 4'(m_mode == 0));
    check("done", 4'(done), 4'(m_mode == 2));
    check("quotient", quotient, m_q);
    check("remainder", remainder, m_r);
    check("div_zero", 4'(div_zero), 4'(m_dz));
  end

  task automatic launch(input logic [3:0] a, input logic [3:0] b);
    int n;
    n = 0;
    while (!ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (!ready) begin
      errors++; vectors++;
      $display("FAIL ready_timeout: ready stayed 0, expected 1");
    end
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait for done (latency counted in cycles after the accepting edge), then
  // compare against hand-computed values.
  task automatic finish_check(input string name, input int lat, input logic [3:0] eq,
                              input logic [3:0] er, input logic edz);
    int n;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!done && n < 40);
    check({name, "_done"}, 4'(done), 4'd1);
    check({name, "_latency"}, 4'(n), 4'(lat));
    check({name, "_q"}, quotient, eq);
    check({name, "_r"}, remainder, er);
    check({name, "_dz"}, 4'(div_zero), 4'(edz));
    @(posedge clk); #1;
  endtask

  initial begin
    vectors = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 4'(ready), 4'd1);
    check("rst_done", 4'(done), 4'd0);
    check("rst_q", quotient, 4'd0);
    check("rst_r", remainder, 4'd0);
    check("rst_dz", 4'(div_zero), 4'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    launch(4'd13, 4'd4); finish_check("d13_4", 5, 4'd3, 4'd1, 1'b0);
    launch(4'd3, 4'd5);  finish_check("d3_5", 2, 4'd0, 4'd3, 1'b0);
    launch(4'd15, 4'd1); finish_check("d15_1", 17, 4'd15, 4'd0, 1'b0);
    launch(4'd7, 4'd0);  finish_check("d7_0", 1, 4'd15, 4'd7, 1'b1);
    launch(4'd8, 4'd2);  finish_check("d8_2", 6, 4'd4, 4'd0, 1'b0);
    launch(4'd0, 4'd3);  finish_check("d0_3", 2, 4'd0, 4'd0, 1'b0);
    launch(4'd6, 4'd6);  finish_check("d6_6", 3, 4'd1, 4'd0, 1'b0);

    // Start pulse while busy must be ignored.
    launch(4'd9, 4'd2);
    @(posedge clk); #1;
    dividend = 4'd1; divisor = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_check("d9_2_busy", 4, 4'd4, 4'd1, 1'b0);

    // Abort mid-division: reset takes effect immediately.
    launch(4'd15, 4'd1);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_ready", 4'(ready), 4'd1);
    check("abort_done", 4'(done), 4'd0);
    check("abort_q", quotient, 4'd0);
    check("abort_r", remainder, 4'd0);
    check("abort_dz", 4'(div_zero), 4'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    launch(4'd6, 4'd3); finish_check("d6_3", 4, 4'd2, 4'd0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
